// File: rtl/aes128_round_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes128_round_sched_if                                                |
// | Plaintext/key input stream and ciphertext output stream bundle.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface aes128_round_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/aes128_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes128_round_sched                                                   |
// | Iterative AES-128 encryptor, one round per clock, on-the-fly keys.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+

// S-box as GF(2^8) inverse (x^254) followed by the affine transform.
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_pow;
    logic [7:0] w_inv;

    always_comb begin
        w_pow = i_byte;
        w_inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            w_pow = gmul(w_pow, w_pow);
            w_inv = gmul(w_inv, w_pow);
        end
        o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module mixcolumn (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = i_state[127-32*c -: 8];
        assign w_a1 = i_state[119-32*c -: 8];
        assign w_a2 = i_state[111-32*c -: 8];
        assign w_a3 = i_state[103-32*c -: 8];
        assign o_state[127-32*c -: 8] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign o_state[119-32*c -: 8] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
        assign o_state[111-32*c -: 8] = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
        assign o_state[103-32*c -: 8] = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
    end
endmodule

module aes128_round_sched #(
    parameter int NR = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    aes128_round_sched_if.slave         bus,
    output logic                        busy,
    output logic [3:0]                  round_cnt
);
    if (NR != 10) begin : g_nr_check
        $error("aes128_round_sched: only NR=10 is supported");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       r_fsm, w_fsm_nxt;
    logic [127:0] r_aes, r_rk, r_out_data;
    logic [7:0]   r_rcon;
    logic [3:0]   r_cnt;
    logic         r_out_valid;

    logic [127:0] w_sb, w_sr, w_mc, w_nk, w_rnd;
    logic [31:0]  w_rot, w_subw, w_tmp;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        sbox u_sbox (.i_byte(r_aes[127-8*i -: 8]), .o_byte(w_sb[127-8*i -: 8]));
    end

    // Byte (row r, col c) takes the byte from column (c + r) mod 4 of the same row.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

    mixcolumn u_mix (.i_state(w_sr), .o_state(w_mc));

    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_subword
        sbox u_sbox (.i_byte(w_rot[31-8*j -: 8]), .o_byte(w_subw[31-8*j -: 8]));
    end

    assign w_tmp          = w_subw ^ {r_rcon, 24'h000000};
    assign w_nk[127:96]   = r_rk[127:96] ^ w_tmp;
    assign w_nk[95:64]    = r_rk[95:64]  ^ w_nk[127:96];
    assign w_nk[63:32]    = r_rk[63:32]  ^ w_nk[95:64];
    assign w_nk[31:0]     = r_rk[31:0]   ^ w_nk[63:32];

    // The last round skips MixColumns.
    assign w_rnd = ((r_fsm == FINAL) ? w_sr : w_mc) ^ w_nk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (bus.in_valid) w_fsm_nxt = ROUND;
            ROUND:   if (r_cnt == 4'(NR - 1)) w_fsm_nxt = FINAL;
            FINAL:   w_fsm_nxt = DONE;
            DONE:    if (bus.out_ready) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aes       <= '0;
            r_rk        <= '0;
            r_rcon      <= 8'h01;
            r_cnt       <= 4'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: if (bus.in_valid) begin
                    r_aes  <= bus.in_data ^ bus.in_key;
                    r_rk   <= bus.in_key;
                    r_rcon <= 8'h01;
                    r_cnt  <= 4'd1;
                end
                ROUND: begin
                    r_aes  <= w_rnd;
                    r_rk   <= w_nk;
                    r_rcon <= xtime(r_rcon);
                    r_cnt  <= r_cnt + 4'd1;
                end
                FINAL: begin
                    r_aes       <= w_rnd;
                    r_rk        <= w_nk;
                    r_rcon      <= xtime(r_rcon);
                    r_out_data  <= w_rnd;
                    r_out_valid <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_cnt       <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_fsm == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = (r_fsm == ROUND) || (r_fsm == FINAL);
    assign round_cnt     = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_aes128_round_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes128_round_sched                                                |
// | Directed known-answer bench for the iterative AES-128 sequencer.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_aes128_round_sched;
    localparam logic [127:0] C_KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [3:0] round_cnt;
    int         n_checks;
    int         n_errors;

    aes128_round_sched_if bus ();

    aes128_round_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one block, waits (bounded) for out_valid, checks latency and data, then drains it.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp);
        int lat;
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        bus.in_data  = pt;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = ~pt;
        bus.in_key   = ~key;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_drained"}, 128'(bus.out_valid), 128'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_round_cnt", 128'(round_cnt), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        rst_n = 1'b1;
        step();

        // FIPS-197 C.1 with round counter trace
        bus.in_valid = 1'b1;
        bus.in_key   = C_KEY_C1;
        bus.in_data  = C_PT_C1;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        bus.in_key   = '1;
        check("c1_cnt_1", 128'(round_cnt), 128'd1);
        check("c1_busy", 128'(busy), 128'd1);
        check("c1_in_ready", 128'(bus.in_ready), 128'd0);
        for (int k = 2; k <= 10; k++) begin
            step();
            check($sformatf("c1_cnt_%0d", k), 128'(round_cnt), 128'(k));
            check($sformatf("c1_no_valid_%0d", k), 128'(bus.out_valid), 128'd0);
        end
        step();
        check("c1_valid", 128'(bus.out_valid), 128'd1);
        check("c1_data", bus.out_data, C_CT_C1);
        check("c1_busy_done", 128'(busy), 128'd0);
        check("c1_cnt_done", 128'(round_cnt), 128'd10);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("c1_valid_drop", 128'(bus.out_valid), 128'd0);
        check("c1_idle", 128'(bus.in_ready), 128'd1);
        check("c1_cnt_clear", 128'(round_cnt), 128'd0);
        check("c1_data_hold", bus.out_data, C_CT_C1);

        // FIPS-197 B with consumer stall and new offers ignored in DONE
        bus.in_valid = 1'b1;
        bus.in_key   = C_KEY_B;
        bus.in_data  = C_PT_B;
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        check("b_valid", 128'(bus.out_valid), 128'd1);
        check("b_data", bus.out_data, C_CT_B);
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        bus.in_key   = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("b_stall_valid_%0d", k), 128'(bus.out_valid), 128'd1);
            check($sformatf("b_stall_data_%0d", k), bus.out_data, C_CT_B);
            check($sformatf("b_stall_in_ready_%0d", k), 128'(bus.in_ready), 128'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("b_idle", 128'(bus.in_ready), 128'd1);

        // Back-to-back with out_ready and in_valid held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_key    = C_KEY_C1;
        bus.in_data   = C_PT_C1;
        step();
        check("bb1_cnt", 128'(round_cnt), 128'd1);
        bus.in_key  = C_KEY_B;
        bus.in_data = C_PT_B;
        repeat (9) step();
        check("bb1_no_valid", 128'(bus.out_valid), 128'd0);
        step();
        check("bb1_valid", 128'(bus.out_valid), 128'd1);
        check("bb1_data", bus.out_data, C_CT_C1);
        step();
        check("bb1_drop", 128'(bus.out_valid), 128'd0);
        check("bb_idle_gap", 128'(bus.in_ready), 128'd1);
        step();
        check("bb2_accepted", 128'(round_cnt), 128'd1);
        check("bb2_busy", 128'(busy), 128'd1);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (9) step();
        check("bb2_no_valid", 128'(bus.out_valid), 128'd0);
        step();
        check("bb2_valid", 128'(bus.out_valid), 128'd1);
        check("bb2_data", bus.out_data, C_CT_B);
        step();
        check("bb2_drop", 128'(bus.out_valid), 128'd0);
        bus.out_ready = 1'b0;

        // Reset in the middle of a block
        bus.in_valid = 1'b1;
        bus.in_key   = C_KEY_C1;
        bus.in_data  = C_PT_C1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("mid_cnt_5", 128'(round_cnt), 128'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 128'(round_cnt), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("mid_rst_out_data", bus.out_data, 128'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("mid_no_valid_%0d", k), 128'(bus.out_valid), 128'd0);
        end
        run_block("mid_c1", C_KEY_C1, C_PT_C1, C_CT_C1);

        // All-zero key and plaintext
        run_block("zero", 128'd0, 128'd0, C_CT_Z);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes128_round_sched.md
Name: aes128_round_sched

Overview:
- Iterative AES-128 encryption sequencer: one round per clock on a 128-bit state register, round key expanded on the fly.
- Reuses the existing combinational mixcolumn (128-bit in/out) and sbox (8-bit in/out) modules: 16 sbox instances for SubBytes, 4 for key expansion.
- Sits between the block-level valid/ready input (plaintext + key) and the ciphertext output stage.
- Byte order: bits [127:120] = state byte 0 (row 0, col 0), column-major, matching mixcolumn.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) supported, any other value is a synthesis error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  block idle, can accept
- in_data  in  128  plaintext
- in_key  in  128  cipher key
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext
- busy  out  1  rounds in progress
- round_cnt  out  4  current round index, 0..10

Behaviour:
- Single clock; reset is asynchronous, active-low (rst_n), and applies immediately on assertion.
- Reset values:
  - FSM = IDLE, in_ready = 1, out_valid = 0, busy = 0, round_cnt = 0.
  - out_data = 0, state register = 0, round-key register = 0, rcon register = 0x01.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: state <= in_data ^ in_key; rk <= in_key; rcon <= 0x01; round_cnt <= 1; go to ROUND.
- ROUND (round_cnt 1..9), every edge:
  - nk = expand(rk, rcon) = standard AES-128 schedule step (RotWord, SubWord, XOR rcon into the MSB of word 0, cascade XOR across words 1-3).
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ nk.
  - rk <= nk; rcon <= xtime(rcon), i.e. shift left, XOR 0x1b on carry out of bit 7.
  - round_cnt increments.
  - After the edge where round_cnt was 9, go to FINAL (round_cnt = 10).
- FINAL (one edge):
  - Same as ROUND but mixcolumn is bypassed.
  - out_data <= result; out_valid <= 1; go to DONE.
- DONE:
  - out_valid = 1; out_data stable.
  - On an edge with out_ready = 1: out_valid <= 0, round_cnt <= 0, go to IDLE.
  - out_data keeps its last value after the handshake.
- Latency: the acceptance edge is E0. out_valid is first high after E10. Throughput is one block per ≥12 cycles.
- Output signal definitions:
  - in_ready = (FSM == IDLE), combinational from the state register.
  - busy = ROUND or FINAL.
- Back-pressure: no new block is accepted in DONE. in_valid is ignored outside IDLE, and in_data/in_key are sampled only at the acceptance edge (may change afterwards).
- out_ready high while out_valid = 0 has no effect. If out_ready is held high, the DONE→IDLE transition happens one edge after out_valid rises.
- rcon sequence over rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Reset asserted mid-operation: all registers return to their reset values immediately; the in-flight block is discarded with no partial out_valid. After rst_n deasserts, the next accepted block computes correctly.
- No X propagation: every register has a reset value; no latches.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles -> in_ready = 1, out_valid = 0, busy = 0, round_cnt = 0, out_data = 0.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising exactly 10 cycles after the acceptance edge, round_cnt stepping 1..10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. With out_ready held 0 for 5 cycles, out_valid and out_data stay stable and in_ready stays 0.
- Back-to-back with out_ready = 1 permanently, in_valid = 1 continuously with the C.1 then B vectors -> two correct ciphertexts in order. The second is accepted the edge after returning to IDLE. in_data changes during busy are ignored.
- Mid-operation reset: pulse rst_n low at round_cnt = 5, then resend C.1 -> no out_valid for the aborted block, then 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and all-zero pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
